// File: rtl/cpu_types.sv
// Shared OOO-core types for the ALU reservation station: tags, ALU op codes,
// operand struct and the CDB snoop helpers.
package cpu_types;

    localparam int TAG_W = 4;
    typedef logic [TAG_W-1:0] RS_tag_type;
    localparam RS_tag_type INVALID = '1;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SUB  = 4'd8,
        ALU_LUI  = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_SRA  = 4'd13
    } alu_fun_t;

    typedef struct packed {
        logic [31:0] val;
        RS_tag_type  Q;
    } rs_operand_t;

    // An INVALID broadcast never matches, including operands that are already ready.
    function automatic logic tag_hit(input RS_tag_type q, input RS_tag_type cdb_tag);
        return (cdb_tag != INVALID) && (q == cdb_tag);
    endfunction

    function automatic rs_operand_t snoop(input rs_operand_t op, input RS_tag_type cdb_tag,
                                          input logic [31:0] cdb_val);
        rs_operand_t r;
        r = op;
        if (tag_hit(op.Q, cdb_tag)) begin
            r.val = cdb_val;
            r.Q   = INVALID;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: op, dest tag, two operands with CDB snoop.
// RS_CDB_WAKEUP_BYPASS_EN lets a slot woken by this cycle's CDB be selected this cycle.
module rs_entry
    import cpu_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        wr_en,
    input  logic        clr,
    input  logic [3:0]  wr_fun,
    input  RS_tag_type  wr_rd_tag,
    input  rs_operand_t wr_op1,
    input  rs_operand_t wr_op2,
    input  RS_tag_type  cdb_tag,
    input  logic [31:0] cdb_val,
    output logic        valid,
    output logic        sel_ready,
    output logic [3:0]  fun,
    output RS_tag_type  rd_tag,
    output logic [31:0] iss_v1,
    output logic [31:0] iss_v2
);

    rs_operand_t op1, op2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            fun    <= '0;
            rd_tag <= INVALID;
            op1    <= '{val: '0, Q: INVALID};
            op2    <= '{val: '0, Q: INVALID};
        end else if (flush) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            // Dispatch bypass: an operand produced on the CDB this very cycle lands ready.
            valid  <= 1'b1;
            fun    <= wr_fun;
            rd_tag <= wr_rd_tag;
            op1    <= snoop(wr_op1, cdb_tag, cdb_val);
            op2    <= snoop(wr_op2, cdb_tag, cdb_val);
        end else if (clr) begin
            valid <= 1'b0;
        end else if (valid) begin
            op1 <= snoop(op1, cdb_tag, cdb_val);
            op2 <= snoop(op2, cdb_tag, cdb_val);
        end
    end

`ifdef RS_CDB_WAKEUP_BYPASS_EN
    always_comb begin
        sel_ready = valid
                 && (op1.Q == INVALID || tag_hit(op1.Q, cdb_tag))
                 && (op2.Q == INVALID || tag_hit(op2.Q, cdb_tag));
        iss_v1 = snoop(op1, cdb_tag, cdb_val).val;
        iss_v2 = snoop(op2, cdb_tag, cdb_val).val;
    end
`else
    always_comb begin
        sel_ready = valid && (op1.Q == INVALID) && (op2.Q == INVALID);
        iss_v1    = op1.val;
        iss_v2    = op2.val;
    end
`endif

endmodule

// File: rtl/otter_alu_rs.sv
// Reservation station in front of the OTTER ALU: lowest-free-slot dispatch,
// lowest-ready-slot issue into a registered ALU interface. Option: RS_CDB_WAKEUP_BYPASS_EN.
module otter_alu_rs
    import cpu_types::*;
#(
    parameter int NUM_ENTRIES = 4
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           flush,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [3:0]                     disp_alu_fun,
    input  RS_tag_type                     disp_rd_tag,
    input  logic [31:0]                    disp_V1,
    input  logic [31:0]                    disp_V2,
    input  RS_tag_type                     disp_Q1,
    input  RS_tag_type                     disp_Q2,
    input  logic [31:0]                    CDB_val,
    input  RS_tag_type                     CDB_tag,
    input  logic                           fu_ready,
    output logic [31:0]                    V1,
    output logic [31:0]                    V2,
    output logic                           V1_valid,
    output logic                           V2_valid,
    output logic [3:0]                     alu_fun,
    output RS_tag_type                     rd_tag,
    output logic [$clog2(NUM_ENTRIES):0]   occupancy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = IDX_W + 1;

    logic [NUM_ENTRIES-1:0]             ent_valid, ent_sel, wr_en, clr;
    logic [NUM_ENTRIES-1:0][3:0]        ent_fun;
    logic [NUM_ENTRIES-1:0][TAG_W-1:0]  ent_rd;
    logic [NUM_ENTRIES-1:0][31:0]       ent_v1, ent_v2;

    logic              free_any, sel_any, disp_fire, issue_go, iss_valid;
    logic [IDX_W-1:0]  free_idx, sel_idx;
    rs_operand_t       disp_op1, disp_op2;

    assign disp_op1 = '{val: disp_V1, Q: disp_Q1};
    assign disp_op2 = '{val: disp_V2, Q: disp_Q2};

    // Both encoders look only at registered slot state (plus CDB when bypass is on).
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        sel_any  = 1'b0;
        sel_idx  = '0;
        for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (ent_sel[i]) begin
                sel_any = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            occupancy = occupancy + OCC_W'(ent_valid[i]);
    end

    assign disp_ready = free_any && !flush;
    assign disp_fire  = disp_valid && disp_ready;
    assign issue_go   = fu_ready && sel_any && !flush;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
        assign wr_en[g] = disp_fire && (free_idx == IDX_W'(g));
        assign clr[g]   = issue_go && (sel_idx == IDX_W'(g));

        rs_entry u_entry (
            .clk       (CLK),
            .rst_n     (RST_N),
            .flush     (flush),
            .wr_en     (wr_en[g]),
            .clr       (clr[g]),
            .wr_fun    (disp_alu_fun),
            .wr_rd_tag (disp_rd_tag),
            .wr_op1    (disp_op1),
            .wr_op2    (disp_op2),
            .cdb_tag   (CDB_tag),
            .cdb_val   (CDB_val),
            .valid     (ent_valid[g]),
            .sel_ready (ent_sel[g]),
            .fun       (ent_fun[g]),
            .rd_tag    (ent_rd[g]),
            .iss_v1    (ent_v1[g]),
            .iss_v2    (ent_v2[g])
        );
    end

    // Issue register: data holds between issues, only valid/rd_tag return to idle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            V1        <= '0;
            V2        <= '0;
            alu_fun   <= '0;
            rd_tag    <= INVALID;
            iss_valid <= 1'b0;
        end else if (flush) begin
            V1        <= '0;
            V2        <= '0;
            alu_fun   <= '0;
            rd_tag    <= INVALID;
            iss_valid <= 1'b0;
        end else if (issue_go) begin
            V1        <= ent_v1[sel_idx];
            V2        <= ent_v2[sel_idx];
            alu_fun   <= ent_fun[sel_idx];
            rd_tag    <= ent_rd[sel_idx];
            iss_valid <= 1'b1;
        end else begin
            rd_tag    <= INVALID;
            iss_valid <= 1'b0;
        end
    end

    assign V1_valid = iss_valid;
    assign V2_valid = iss_valid;

endmodule

// File: tb/tb_otter_alu_rs.sv
// Directed bench for otter_alu_rs; expectations follow RS_CDB_WAKEUP_BYPASS_EN when defined.
module tb_otter_alu_rs;

    localparam logic [3:0] INV = 4'hF;

    logic        CLK, RST_N, flush, disp_valid, disp_ready, fu_ready;
    logic [3:0]  disp_alu_fun, disp_rd_tag, disp_Q1, disp_Q2, CDB_tag, alu_fun, rd_tag;
    logic [31:0] disp_V1, disp_V2, CDB_val, V1, V2;
    logic        V1_valid, V2_valid;
    logic [2:0]  occupancy;

    int n_vec = 0;
    int n_err = 0;

    otter_alu_rs #(.NUM_ENTRIES(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_alu_fun(disp_alu_fun), .disp_rd_tag(disp_rd_tag),
        .disp_V1(disp_V1), .disp_V2(disp_V2), .disp_Q1(disp_Q1), .disp_Q2(disp_Q2),
        .CDB_val(CDB_val), .CDB_tag(CDB_tag), .fu_ready(fu_ready),
        .V1(V1), .V2(V2), .V1_valid(V1_valid), .V2_valid(V2_valid),
        .alu_fun(alu_fun), .rd_tag(rd_tag), .occupancy(occupancy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic disp(input logic [3:0] fun, input logic [3:0] rd,
                        input logic [31:0] v1, input logic [3:0] q1,
                        input logic [31:0] v2, input logic [3:0] q2);
        disp_valid   = 1'b1;
        disp_alu_fun = fun;
        disp_rd_tag  = rd;
        disp_V1      = v1;
        disp_Q1      = q1;
        disp_V2      = v2;
        disp_Q2      = q2;
    endtask

    initial begin
        RST_N = 1'b0; flush = 1'b0; fu_ready = 1'b0;
        disp_valid = 1'b0; disp_alu_fun = '0; disp_rd_tag = '0;
        disp_V1 = '0; disp_V2 = '0; disp_Q1 = INV; disp_Q2 = INV;
        CDB_val = '0; CDB_tag = INV;
        #12;
        chk("rst_v1_valid", V1_valid, 0);
        chk("rst_v2_valid", V2_valid, 0);
        chk("rst_rd_tag", rd_tag, INV);
        chk("rst_occ", occupancy, 0);
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_v1", V1, 0);
        chk("rst_alu_fun", alu_fun, 0);
        @(negedge CLK) RST_N = 1'b1;
        tick;
        fu_ready = 1'b1;

        // 1: both operands ready, issue two edges after dispatch
        disp(4'd0, 4'd1, 32'd5, INV, 32'd7, INV);
        tick;
        disp_valid = 1'b0;
        chk("t1_not_yet", V1_valid, 0);
        chk("t1_occ1", occupancy, 1);
        tick;
        chk("t1_valid", V1_valid, 1);
        chk("t1_v2_valid", V2_valid, 1);
        chk("t1_v1", V1, 5);
        chk("t1_v2", V2, 7);
        chk("t1_fun", alu_fun, 0);
        chk("t1_rd", rd_tag, 1);
        chk("t1_occ0", occupancy, 0);
        tick;
        chk("t1_idle_valid", V1_valid, 0);
        chk("t1_idle_rd", rd_tag, INV);

        // 2: wait on T3 via CDB wakeup
        disp(4'd8, 4'd2, 32'd0, 4'd3, 32'd4, INV);
        tick;
        disp_valid = 1'b0;
        chk("t2_occ", occupancy, 1);
        tick;
        tick;
        chk("t2_waiting", V1_valid, 0);
        CDB_tag = 4'd3; CDB_val = 32'h10;
        tick;
        CDB_tag = INV; CDB_val = 32'h0;
`ifndef RS_CDB_WAKEUP_BYPASS_EN
        chk("t2_wake_no_issue", V1_valid, 0);
        chk("t2_wake_occ", occupancy, 1);
        tick;
`endif
        chk("t2_valid", V1_valid, 1);
        chk("t2_v1", V1, 32'h10);
        chk("t2_v2", V2, 4);
        chk("t2_fun", alu_fun, 8);
        chk("t2_rd", rd_tag, 2);
        tick;

        // 3: operand arrives on the CDB in the dispatch cycle
        disp(4'd6, 4'd5, 32'd1, INV, 32'd0, 4'd2);
        CDB_tag = 4'd2; CDB_val = 32'd9;
        tick;
        disp_valid = 1'b0; CDB_tag = INV; CDB_val = 32'h0;
        chk("t3_occ", occupancy, 1);
        chk("t3_not_yet", V1_valid, 0);
        tick;
        chk("t3_valid", V1_valid, 1);
        chk("t3_v2", V2, 9);
        chk("t3_v1", V1, 1);
        chk("t3_rd", rd_tag, 5);
        chk("t3_fun", alu_fun, 6);
        tick;

        // one CDB tag satisfies both operands of a slot
        disp(4'd0, 4'd6, 32'd0, 4'd8, 32'd0, 4'd8);
        tick;
        disp_valid = 1'b0;
        CDB_tag = 4'd8; CDB_val = 32'h33;
        tick;
        CDB_tag = INV; CDB_val = 32'h0;
`ifndef RS_CDB_WAKEUP_BYPASS_EN
        chk("dual_no_issue", V1_valid, 0);
        tick;
`endif
        chk("dual_valid", V1_valid, 1);
        chk("dual_v1", V1, 32'h33);
        chk("dual_v2", V2, 32'h33);
        tick;

        // dispatch and issue on the same edge
        disp(4'd0, 4'd1, 32'hA, INV, 32'hB, INV);
        tick;
        disp(4'd4, 4'd2, 32'hC, INV, 32'hD, INV);
        tick;
        disp_valid = 1'b0;
        chk("same_rd1", rd_tag, 1);
        chk("same_occ1", occupancy, 1);
        tick;
        chk("same_rd2", rd_tag, 2);
        chk("same_v1", V1, 32'hC);
        chk("same_occ0", occupancy, 0);
        tick;

        // 4: fill with fu_ready low, then drain in slot order
        fu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(4'd10, 4'(4 + i), 32'(i + 1), INV, 32'(i + 100), INV);
            tick;
        end
        chk("full_occ", occupancy, 4);
        chk("full_ready", disp_ready, 0);
        chk("full_no_issue", V1_valid, 0);
        disp(4'd0, 4'd9, 32'd55, INV, 32'd66, INV);
        tick;
        disp_valid = 1'b0;
        chk("full_ignored_occ", occupancy, 4);
        fu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("drain_valid", V1_valid, 1);
            chk("drain_rd", rd_tag, 32'(4 + i));
            chk("drain_v1", V1, 32'(i + 1));
            chk("drain_v2", V2, 32'(i + 100));
            chk("drain_occ", occupancy, 32'(3 - i));
        end
        tick;
        chk("drain_idle", V1_valid, 0);

        // 5: flush drops slots, same-cycle dispatch and a pending issue
        fu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(4'd0, 4'(10 + i), 32'd1, INV, 32'd2, INV);
            tick;
        end
        chk("pre_flush_occ", occupancy, 3);
        disp(4'd13, 4'hA, 32'd3, INV, 32'd4, INV);
        flush = 1'b1; fu_ready = 1'b1;
        #1;
        chk("flush_disp_ready", disp_ready, 0);
        tick;
        flush = 1'b0; disp_valid = 1'b0;
        chk("flush_occ", occupancy, 0);
        chk("flush_valid", V1_valid, 0);
        chk("flush_rd", rd_tag, INV);
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("post_flush_valid", V1_valid, 0);
            chk("post_flush_occ", occupancy, 0);
        end

        // 6: asynchronous reset during an issue cycle
        disp(4'd1, 4'd3, 32'h77, INV, 32'd1, INV);
        tick;
        disp_valid = 1'b0;
        tick;
        chk("pre_rst_valid", V1_valid, 1);
        chk("pre_rst_rd", rd_tag, 3);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_valid", V1_valid, 0);
        chk("arst_rd", rd_tag, INV);
        chk("arst_v1", V1, 0);
        chk("arst_occ", occupancy, 0);
        @(negedge CLK) RST_N = 1'b1;
        tick;
        chk("post_rst_valid", V1_valid, 0);
        chk("post_rst_ready", disp_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
